// File: rtl/dualport_ram_be_pkg.sv
// Shared helpers for the byte-enable dual-port RAM: lane sizing, lane merge and address qualification.
package dualport_ram_be_pkg;

    localparam int MAX_WIDTH  = 512;
    localparam int MAX_LANES  = 64;
    localparam int MAX_ADDR_W = 32;

    function automatic int lane_width(input int width, input int num_be);
        return width / num_be;
    endfunction

    // Lanes with be set take new_word, all others keep old_word.
    function automatic logic [MAX_WIDTH-1:0] be_merge(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_LANES-1:0] be,
        input int                   lw
    );
        logic [MAX_WIDTH-1:0] lane_ones;
        logic [MAX_WIDTH-1:0] mask;
        lane_ones = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - lw);
        mask      = '0;
        for (int k = 0; k < MAX_LANES; k++) begin
            if (be[k]) mask = mask | (lane_ones << (k * lw));
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    function automatic logic addr_ok(input logic [MAX_ADDR_W-1:0] addr, input int words);
        return !$isunknown(addr) && (addr < $unsigned(words));
    endfunction

endpackage

// File: rtl/ram_be_out_pipe.sv
// Output register chain for the RAM read path: STAGES deep {valid,data} shift register, stalled by en.
module ram_be_out_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_regs
            logic             vld_pn  [STAGES];
            logic [WIDTH-1:0] data_pn [STAGES];

            // Data only advances alongside a valid, so the output keeps the last read result.
            always_ff @(posedge clk or posedge a_rst) begin
                if (a_rst) begin
                    for (int i = 0; i < STAGES; i++) begin
                        vld_pn[i]  <= 1'b0;
                        data_pn[i] <= '0;
                    end
                end else if (en) begin
                    vld_pn[0] <= in_valid;
                    if (in_valid) data_pn[0] <= in_data;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_pn[i] <= vld_pn[i-1];
                        if (vld_pn[i-1]) data_pn[i] <= data_pn[i-1];
                    end
                end
            end

            assign out_valid = vld_pn[STAGES-1];
            assign out_data  = data_pn[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/dualport_ram_be_pipe.sv
// Simple-dual-port byte-enable RAM with pipelined read, global stall and sticky out-of-bound flag.
// Define DUALPORT_RAM_BE_FWD_EN to forward same-edge write data to a same-address read (else old data).
module dualport_ram_be_pipe
    import dualport_ram_be_pkg::*;
#(
    parameter int WORDS            = 256,
    parameter int WIDTH            = 32,
    parameter int ADDR_WIDTH       = 8,
    parameter int NUM_BYTE_ENABLES = 4,
    parameter int NUM_OUT_REGS     = 1
) (
    input  logic                        clk,
    input  logic                        a_rst,
    input  logic                        en,
    input  logic                        wr_en,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [NUM_BYTE_ENABLES-1:0] wr_be,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    input  logic                        err_clr,
    output logic                        oob_err
);

    localparam int LW = lane_width(WIDTH, NUM_BYTE_ENABLES);

    logic [WIDTH-1:0] mem [WORDS];

    logic             wr_ok;
    logic             rd_ok;
    logic             wr_fire;
    logic [WIDTH-1:0] wr_word;
    logic [WIDTH-1:0] rd_word;
    logic             vld_p0;
    logic [WIDTH-1:0] rd_data_p0;

    assign wr_ok   = addr_ok(MAX_ADDR_W'(wr_addr), WORDS);
    assign rd_ok   = addr_ok(MAX_ADDR_W'(rd_addr), WORDS);
    assign wr_fire = en && wr_en && wr_ok;
    assign wr_word = WIDTH'(be_merge(MAX_WIDTH'(mem[wr_addr]), MAX_WIDTH'(wr_data),
                                     MAX_LANES'(wr_be), LW));

`ifdef DUALPORT_RAM_BE_FWD_EN
    assign rd_word = (wr_fire && (wr_addr == rd_addr)) ? wr_word : mem[rd_addr];
`else
    assign rd_word = mem[rd_addr];
`endif

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= wr_word;
    end

    // Stage p0: RAM read register; out-of-bound reads still return a valid zero word.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            vld_p0     <= 1'b0;
            rd_data_p0 <= '0;
        end else if (en) begin
            vld_p0 <= rd_en;
            if (rd_en) rd_data_p0 <= rd_ok ? rd_word : '0;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            oob_err <= 1'b0;
        end else if (en) begin
            if ((wr_en && !wr_ok) || (rd_en && !rd_ok)) oob_err <= 1'b1;
            else if (err_clr)                            oob_err <= 1'b0;
        end
    end

    ram_be_out_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (NUM_OUT_REGS)
    ) u_out_pipe (
        .clk       (clk),
        .a_rst     (a_rst),
        .en        (en),
        .in_valid  (vld_p0),
        .in_data   (rd_data_p0),
        .out_valid (rd_valid),
        .out_data  (rd_data)
    );

endmodule

// File: tb/tb_dualport_ram_be_pipe.sv
// Directed bench for dualport_ram_be_pipe: reference memory model plus a scoreboard of expected reads.
module tb_dualport_ram_be_pipe;

    localparam int WORDS = 200;
    localparam int WIDTH = 32;
    localparam int AW    = 8;
    localparam int NBE   = 4;
    localparam int R     = 2;

    logic             clk = 1'b0;
    logic             a_rst;
    logic             en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [NBE-1:0]   wr_be;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             err_clr;
    logic             oob_err;

    always #5 clk = ~clk;

    dualport_ram_be_pipe #(
        .WORDS            (WORDS),
        .WIDTH            (WIDTH),
        .ADDR_WIDTH       (AW),
        .NUM_BYTE_ENABLES (NBE),
        .NUM_OUT_REGS     (R)
    ) dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .en       (en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .err_clr  (err_clr),
        .oob_err  (oob_err)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } sb_t;

    sb_t              sb[$];
    logic [WIDTH-1:0] model [WORDS];
    logic             exp_oob  = 1'b0;
    int               ecyc     = 0;
    int               n_checks = 0;
    int               n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        logic [31:0] exp_d;
        logic [31:0] prev_d;
        logic        prev_v;
        logic        rok;
        logic        wok;
        sb_t         e;
        prev_d = rd_data;
        prev_v = rd_valid;
        if (en && !a_rst) begin
            rok = int'(rd_addr) < WORDS;
            wok = int'(wr_addr) < WORDS;
            if (rd_en) begin
                exp_d = rok ? model[rd_addr] : 32'h0;
`ifdef DUALPORT_RAM_BE_FWD_EN
                if (rok && wr_en && wok && wr_addr == rd_addr) exp_d = merge(exp_d, wr_data, wr_be);
`endif
                e.data = exp_d;
                e.cyc  = ecyc;
                sb.push_back(e);
            end
            if (wr_en && wok) model[wr_addr] = merge(model[wr_addr], wr_data, wr_be);
            if ((wr_en && !wok) || (rd_en && !rok)) exp_oob = 1'b1;
            else if (err_clr)                       exp_oob = 1'b0;
        end
        @(posedge clk);
        #1;
        if (en) begin
            ecyc++;
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(rd_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_data", rd_data, e.data);
                    check("rd_latency", ecyc - e.cyc, 1 + R);
                end
            end else if (sb.size() > 0 && (ecyc - sb[0].cyc) > 1 + R) begin
                e = sb.pop_front();
                check("missing_valid", 32'(rd_valid), 32'd1);
            end
        end else begin
            check("stall_valid", 32'(rd_valid), 32'(prev_v));
            check("stall_data", rd_data, prev_d);
        end
        check("oob_err", 32'(oob_err), 32'(exp_oob));
    endtask

    task automatic idle();
        en      = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * (R + 2) && sb.size() > 0; i++) tick();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst = 1'b1; en = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        #1;
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_oob_err", 32'(oob_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        idle();

        // Full write then read.
        wr(8'd5, 32'hDEADBEEF, 4'hF);
        rd(8'd5);
        drain();

        // Partial write, then a zero-enable write that must change nothing.
        wr(8'd5, 32'h11223344, 4'b0101);
        wr(8'd5, 32'h55555555, 4'b0000);
        rd(8'd5);
        drain();

        // Same-edge write and read of one address.
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hAAAAAAAA; wr_be = 4'b0011;
        rd_en = 1'b1; rd_addr = 8'd5;
        tick();
        idle();
        rd(8'd5);
        drain();

        // Concurrent write and read to different addresses.
        wr(8'd7, 32'h01020304, 4'hF);
        wr_en = 1'b1; wr_addr = 8'd8; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd7;
        tick();
        idle();
        rd(8'd8);
        drain();

        // Back-to-back reads with a three-cycle stall; stalled requests are ignored.
        for (int i = 10; i < 16; i++) wr(8'(i), 32'h1000_0000 + 32'(i * 17), 4'hF);
        for (int i = 10; i < 13; i++) begin
            rd_en = 1'b1; rd_addr = 8'(i);
            tick();
        end
        en = 1'b0; wr_en = 1'b1; wr_addr = 8'd10; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'd99;
        repeat (3) tick();
        en = 1'b1; wr_en = 1'b0;
        for (int i = 13; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 8'(i);
            tick();
        end
        idle();
        rd(8'd10);
        drain();

        // Out-of-bound write and read, then error-clear priority and stall behaviour.
        wr(8'd199, 32'h19919919, 4'hF);
        wr(8'd200, 32'hBADBAD00, 4'hF);
        rd(8'd255);
        drain();
        rd(8'd199);
        drain();
        err_clr = 1'b1; rd_en = 1'b1; rd_addr = 8'd255;
        tick();
        rd_en = 1'b0; en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        idle();
        drain();

        // Asynchronous reset with two reads in flight; memory must survive.
        wr(8'd20, 32'h20202020, 4'hF);
        wr(8'd21, 32'h21212121, 4'hF);
        rd(8'd20);
        rd(8'd21);
        #1;
        a_rst = 1'b1;
        #1;
        check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("async_rst_rd_data", rd_data, 32'd0);
        sb.delete();
        exp_oob = 1'b0;
        @(posedge clk);
        #2;
        a_rst = 1'b0;
        repeat (R + 3) tick();
        rd(8'd20);
        rd(8'd21);
        rd(8'd5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
